// File: rtl/flash_pkg.sv
// Shared encodings for the NOR-flash controller: request ops, flash commands,
// status register bits, sequencer states and bus-phase states.
package flash_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    localparam logic [15:0] CMD_READ_ARRAY    = 16'h00FF;
    localparam logic [15:0] CMD_PROGRAM       = 16'h0040;
    localparam logic [15:0] CMD_ERASE         = 16'h0020;
    localparam logic [15:0] CMD_ERASE_CONFIRM = 16'h00D0;
    localparam logic [15:0] CMD_READ_STATUS   = 16'h0070;
    localparam logic [15:0] CMD_CLEAR_STATUS  = 16'h0050;

    localparam int STS_READY     = 7;
    localparam int STS_ERASE_ERR = 5;
    localparam int STS_PROG_ERR  = 4;
    localparam int STS_VPEN_ERR  = 3;
    localparam int STS_LOCK_ERR  = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD1,
        ST_CMD2,
        ST_RD_ARRAY,
        ST_POLL_CMD,
        ST_POLL_RD,
        ST_CLR_STS,
        ST_RST_ARRAY,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_STROBE,
        PH_HOLD
    } phase_e;

    function automatic logic status_err(input logic [7:0] sts);
        return sts[STS_ERASE_ERR] | sts[STS_PROG_ERR] | sts[STS_VPEN_ERR] | sts[STS_LOCK_ERR];
    endfunction

    function automatic logic is_bus_state(input state_e s);
        return s inside {ST_CMD1, ST_CMD2, ST_RD_ARRAY, ST_POLL_CMD, ST_POLL_RD, ST_CLR_STS, ST_RST_ARRAY};
    endfunction

endpackage

// File: rtl/flash_bus_phy.sv
// Executes one flash bus primitive (WR or RD): strobe phase then hold phase,
// each PHASE_CYC clocks. A new start is taken while idle or on the done cycle.
module flash_bus_phy
    import flash_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int PHASE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W:0]   flash_addr_o,
    output logic              flash_oe_o,
    output logic              flash_we_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_en_o
);

    localparam int TMR_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PHASE_CYC - 1);

    phase_e            phase_q, phase_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              phase_end;

    assign phase_end = (tmr_q == TMR_LAST);
    assign idle_o    = (phase_q == PH_IDLE);
    assign done_o    = (phase_q == PH_HOLD) && phase_end;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can infer a latch.
        phase_d = phase_q;
        tmr_d   = tmr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (phase_q)
            PH_STROBE: begin
                if (phase_end) begin
                    phase_d = PH_HOLD;
                    tmr_d   = '0;
                    if (rd_q) rdata_d = din_i;  // sample on the last clock of OE low
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            PH_HOLD: begin
                if (phase_end) phase_d = PH_IDLE;
                else           tmr_d   = tmr_q + 1'b1;
            end
            default: ;
        endcase
        if (start_i && (idle_o || done_o)) begin
            phase_d = PH_STROBE;
            tmr_d   = '0;
            rd_d    = rd_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) begin
            phase_q <= PH_IDLE;
            tmr_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign flash_addr_o = {addr_q, 1'b0};
    assign flash_we_o   = !((phase_q == PH_STROBE) && !rd_q);
    assign flash_oe_o   = !((phase_q == PH_STROBE) && rd_q);
    assign dout_o       = wdata_q;
    assign dout_en_o    = (phase_q != PH_IDLE) && !rd_q;

endmodule

// File: rtl/flash_rw_ctrl.sv
// NOR-flash READ / PROGRAM / BLOCK ERASE controller with status polling.
// The FSM sequences WR/RD primitives executed by flash_bus_phy.
module flash_rw_ctrl
    import flash_pkg::*;
#(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 16,
    parameter int PHASE_CYC = 4,
    parameter int POLL_MAX  = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W:0]   flash_addr,
    inout  wire  [DATA_W-1:0] flash_data,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic              flash_ce,
    output logic              flash_rp,
    output logic              flash_oe,
    output logic              flash_we
);

    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_MAX - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [PCNT_W-1:0] poll_q, poll_d;

    logic              phy_start, phy_rd, phy_idle, phy_done, phy_dout_en;
    logic [DATA_W-1:0] phy_wdata, phy_rdata, phy_dout;
    logic [7:0]        sts;
    logic              poll_last;

    assign sts       = phy_rdata[7:0];
    assign poll_last = (poll_q == POLL_LAST);

    flash_bus_phy #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .PHASE_CYC(PHASE_CYC)
    ) u_phy (
        .clk         (clk),
        .rst         (rst),
        .start_i     (phy_start),
        .rd_i        (phy_rd),
        .addr_i      (addr_d),
        .wdata_i     (phy_wdata),
        .din_i       (flash_data),
        .idle_o      (phy_idle),
        .done_o      (phy_done),
        .rdata_o     (phy_rdata),
        .flash_addr_o(flash_addr),
        .flash_oe_o  (flash_oe),
        .flash_we_o  (flash_we),
        .dout_o      (phy_dout),
        .dout_en_o   (phy_dout_en)
    );

    assign flash_data = phy_dout_en ? phy_dout : 'z;
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_ce   = 1'b0;
    assign flash_rp   = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (req_valid) state_d = (op_e'(req_op) == OP_RSVD) ? ST_RESP : ST_CMD1;
            ST_CMD1:      if (phy_done) state_d = (op_q == OP_READ) ? ST_RD_ARRAY : ST_CMD2;
            ST_CMD2:      if (phy_done) state_d = ST_POLL_CMD;
            ST_RD_ARRAY:  if (phy_done) state_d = ST_RESP;
            ST_POLL_CMD:  if (phy_done) state_d = ST_POLL_RD;
            ST_POLL_RD: begin
                if (phy_done) begin
                    if (sts[STS_READY]) state_d = status_err(sts) ? ST_CLR_STS : ST_RST_ARRAY;
                    else if (poll_last) state_d = ST_RST_ARRAY;
                end
            end
            ST_CLR_STS:   if (phy_done) state_d = ST_RST_ARRAY;
            ST_RST_ARRAY: if (phy_done) state_d = ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Primitive for the state being entered, so consecutive steps run back to back.
    always_comb begin
        phy_rd    = 1'b0;
        phy_wdata = '0;
        case (state_d)
            ST_CMD1: phy_wdata = (op_d == OP_READ)    ? DATA_W'(CMD_READ_ARRAY) :
                                 (op_d == OP_PROGRAM) ? DATA_W'(CMD_PROGRAM) : DATA_W'(CMD_ERASE);
            ST_CMD2:      phy_wdata = (op_d == OP_PROGRAM) ? wdata_d : DATA_W'(CMD_ERASE_CONFIRM);
            ST_POLL_CMD:  phy_wdata = DATA_W'(CMD_READ_STATUS);
            ST_CLR_STS:   phy_wdata = DATA_W'(CMD_CLEAR_STATUS);
            ST_RST_ARRAY: phy_wdata = DATA_W'(CMD_READ_ARRAY);
            ST_RD_ARRAY, ST_POLL_RD: phy_rd = 1'b1;
            default: ;
        endcase
        phy_start  = is_bus_state(state_d) && (phy_idle || phy_done);
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        poll_d  = poll_q;
        if ((state_q == ST_IDLE) && req_valid) begin
            op_d    = op_e'(req_op);
            addr_d  = req_addr;
            wdata_d = req_wdata;
            rdata_d = '0;
            err_d   = (op_e'(req_op) == OP_RSVD);
            poll_d  = '0;
        end
        if (phy_done && (state_q == ST_RD_ARRAY)) rdata_d = phy_rdata;
        if (phy_done && (state_q == ST_POLL_RD)) begin
            rdata_d = phy_rdata;
            poll_d  = poll_q + 1'b1;
            if (sts[STS_READY]) err_d = status_err(sts);
            else if (poll_last) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            poll_q  <= '0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
        end
    end

endmodule

// File: tb/tb_flash_rw_ctrl.sv
// Scoreboard bench for flash_rw_ctrl: a behavioural flash model, expected bus
// cycles and responses queued by the stimulus and popped by separate monitors.
module tb_flash_rw_ctrl;

    localparam int AW   = 22;
    localparam int DW   = 16;
    localparam int PC   = 2;
    localparam int PMAX = 8;

    typedef struct packed {
        logic          is_rd;
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } bus_ev_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          chk_rdata;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW:0]   flash_addr;
    wire  [DW-1:0] flash_data;
    logic          flash_byte, flash_vpen, flash_ce, flash_rp, flash_oe, flash_we;

    int      n_tests = 0;
    int      n_fail  = 0;
    bus_ev_t exp_bus[$];
    resp_t   exp_resp[$];
    bit      mon_en     = 1'b0;
    bit      bus_ignore = 1'b0;

    // Flash model state
    logic          status_mode = 1'b0;
    int            busy_left   = 0;
    bit            never_ready = 1'b0;
    logic [DW-1:0] final_sts   = '0;
    logic [DW-1:0] busy_sts    = '0;
    logic [DW-1:0] array_val   = '0;
    logic [DW-1:0] model_dout;

    always #5 clk = ~clk;

    flash_rw_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .PHASE_CYC(PC),
        .POLL_MAX (PMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .flash_addr(flash_addr),
        .flash_data(flash_data),
        .flash_byte(flash_byte),
        .flash_vpen(flash_vpen),
        .flash_ce  (flash_ce),
        .flash_rp  (flash_rp),
        .flash_oe  (flash_oe),
        .flash_we  (flash_we)
    );

    always_comb model_dout = status_mode ? ((busy_left > 0) ? busy_sts : final_sts) : array_val;
    assign flash_data = !flash_oe ? model_dout : 'z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_seen(input bus_ev_t obs);
        bus_ev_t e;
        if (exp_bus.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_unexpected: got rd=%0d addr=0x%0h data=0x%0h, required no bus cycle",
                     obs.is_rd, obs.addr, obs.data);
        end else begin
            e = exp_bus.pop_front();
            check("bus_cycle {rd,addr,data}", 64'(obs), 64'(e));
        end
    endtask

    task automatic push_wr(input logic [DW-1:0] d, input logic [AW:0] ba);
        exp_bus.push_back('{is_rd: 1'b0, addr: ba, data: d});
    endtask

    task automatic push_rd(input logic [AW:0] ba);
        exp_bus.push_back('{is_rd: 1'b1, addr: ba, data: '0});
    endtask

    // Flash model + bus monitor: commands captured on WE rising, reads logged on OE rising.
    always @(posedge flash_we) begin
        bus_ev_t obs;
        #1;
        if (flash_data == 16'h0070) status_mode = 1'b1;
        else if (flash_data == 16'h00FF) status_mode = 1'b0;
        obs = '{is_rd: 1'b0, addr: flash_addr, data: flash_data};
        if (mon_en && !bus_ignore) bus_seen(obs);
    end

    always @(posedge flash_oe) begin
        bus_ev_t obs;
        if (status_mode && !never_ready && busy_left > 0) busy_left--;
        obs = '{is_rd: 1'b1, addr: flash_addr, data: '0};
        if (mon_en && !bus_ignore) bus_seen(obs);
    end

    // Response monitor
    always @(negedge clk) begin
        resp_t e;
        if (mon_en && resp_valid) begin
            if (exp_resp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got rdata=0x%0h err=%0d, required no response", resp_rdata, resp_err);
            end else begin
                e = exp_resp.pop_front();
                if (e.chk_rdata) check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                check("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
        if (mon_en && !flash_oe && !flash_we) begin
            n_fail++;
            $display("FAIL strobe_overlap: got oe=0 we=0, required at most one low");
        end
    end

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit hold, output int lat);
        int budget;
        lat = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = d;
        budget    = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept_timeout: got ready=0 for %0d cycles, required 1", budget);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_busy", 64'(req_ready), 64'd0);
        if (!hold) req_valid = 1'b0;
        budget = 2;
        while (!resp_valid && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 1'b0;
        if (!resp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid in %0d cycles, required one", budget);
        end else begin
            lat = budget;
        end
    endtask

    // Hand-computed read vectors: word address, byte address, array data
    logic [AW-1:0] rd_addr [10] = '{22'h000123, 22'h000000, 22'h3FFFFF, 22'h155555, 22'h2AAAAA,
                                    22'h000001, 22'h200000, 22'h0ABCDE, 22'h3FFFFE, 22'h000123};
    logic [AW:0]   rd_baddr[10] = '{23'h000246, 23'h000000, 23'h7FFFFE, 23'h2AAAAA, 23'h555554,
                                    23'h000002, 23'h400000, 23'h1579BC, 23'h7FFFFC, 23'h000246};
    logic [DW-1:0] rd_data [10] = '{16'hBEEF, 16'h0000, 16'hFFFF, 16'h1234, 16'hA5A5,
                                    16'h8001, 16'h7FFE, 16'hCAFE, 16'h0F0F, 16'h5AA5};

    initial begin
        int lat;
        int read_lat;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        read_lat  = -1;
        repeat (3) @(negedge clk);

        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        check("rst_flash_oe",   64'(flash_oe),   64'd1);
        check("rst_flash_we",   64'(flash_we),   64'd1);
        check("rst_flash_addr", 64'(flash_addr), 64'd0);
        check("const_pins {byte,vpen,ce,rp}", 64'({flash_byte, flash_vpen, flash_ce, flash_rp}), 64'b1101);
        rst    = 1'b0;
        mon_en = 1'b1;

        // READ: latency must be constant across all reads
        for (int i = 0; i < 10; i++) begin
            array_val = rd_data[i];
            push_wr(16'h00FF, rd_baddr[i]);
            push_rd(rd_baddr[i]);
            exp_resp.push_back('{rdata: rd_data[i], chk_rdata: 1'b1, err: 1'b0});
            issue(2'd0, rd_addr[i], 16'h0000, (i == 9), lat);
            if (i == 0) begin
                read_lat = lat;
                check("read_lat_in_range", 64'((lat >= 4*PC) && (lat <= 4*PC + 2)), 64'd1);
            end else begin
                check("read_lat_constant", 64'(lat), 64'(read_lat));
            end
        end

        // PROGRAM, busy for 3 polls
        busy_left = 3;
        final_sts = 16'h0080;
        push_wr(16'h0040, 23'h000020);
        push_wr(16'h55AA, 23'h000020);
        push_wr(16'h0070, 23'h000020);
        for (int i = 0; i < 4; i++) push_rd(23'h000020);
        push_wr(16'h00FF, 23'h000020);
        exp_resp.push_back('{rdata: 16'h0080, chk_rdata: 1'b1, err: 1'b0});
        issue(2'd1, 22'h000010, 16'h55AA, 1'b0, lat);

        // PROGRAM with program-error and lock-error bits set
        busy_left = 0;
        final_sts = 16'h0092;
        push_wr(16'h0040, 23'h7FFFFE);
        push_wr(16'h0000, 23'h7FFFFE);
        push_wr(16'h0070, 23'h7FFFFE);
        push_rd(23'h7FFFFE);
        push_wr(16'h0050, 23'h7FFFFE);
        push_wr(16'h00FF, 23'h7FFFFE);
        exp_resp.push_back('{rdata: 16'h0092, chk_rdata: 1'b1, err: 1'b1});
        issue(2'd1, 22'h3FFFFF, 16'h0000, 1'b0, lat);

        // PROGRAM where only non-error bits 6 and 2 accompany ready
        busy_left = 1;
        final_sts = 16'h00C4;
        push_wr(16'h0040, 23'h000002);
        push_wr(16'hFFFF, 23'h000002);
        push_wr(16'h0070, 23'h000002);
        push_rd(23'h000002);
        push_rd(23'h000002);
        push_wr(16'h00FF, 23'h000002);
        exp_resp.push_back('{rdata: 16'h00C4, chk_rdata: 1'b1, err: 1'b0});
        issue(2'd1, 22'h000001, 16'hFFFF, 1'b0, lat);

        // ERASE with erase-error bit 5
        busy_left = 0;
        final_sts = 16'h00A0;
        push_wr(16'h0020, 23'h040000);
        push_wr(16'h00D0, 23'h040000);
        push_wr(16'h0070, 23'h040000);
        push_rd(23'h040000);
        push_wr(16'h0050, 23'h040000);
        push_wr(16'h00FF, 23'h040000);
        exp_resp.push_back('{rdata: 16'h00A0, chk_rdata: 1'b1, err: 1'b1});
        issue(2'd2, 22'h020000, 16'h0000, 1'b0, lat);

        // ERASE that never becomes ready: exactly PMAX status reads
        never_ready = 1'b1;
        busy_left   = 1;
        busy_sts    = 16'h0042;
        push_wr(16'h0020, 23'h00000A);
        push_wr(16'h00D0, 23'h00000A);
        push_wr(16'h0070, 23'h00000A);
        for (int i = 0; i < 8; i++) push_rd(23'h00000A);
        push_wr(16'h00FF, 23'h00000A);
        exp_resp.push_back('{rdata: 16'h0042, chk_rdata: 1'b1, err: 1'b1});
        issue(2'd2, 22'h000005, 16'h0000, 1'b0, lat);
        @(negedge clk);
        check("ready_after_timeout", 64'(req_ready), 64'd1);

        // Reset in the middle of an ERASE: no response, everything idle next cycle
        bus_ignore = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 22'h000007;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_flash_oe",   64'(flash_oe),   64'd1);
        check("midrst_flash_we",   64'(flash_we),   64'd1);
        check("midrst_req_ready",  64'(req_ready),  64'd1);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("midrst_flash_addr", 64'(flash_addr), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        bus_ignore  = 1'b0;
        never_ready = 1'b0;
        busy_left   = 0;
        busy_sts    = '0;

        // READ after the aborted ERASE
        array_val = 16'h1357;
        push_wr(16'h00FF, 23'h000246);
        push_rd(23'h000246);
        exp_resp.push_back('{rdata: 16'h1357, chk_rdata: 1'b1, err: 1'b0});
        issue(2'd0, 22'h000123, 16'h0000, 1'b0, lat);
        check("read_lat_after_reset", 64'(lat), 64'(read_lat));

        // Reserved op with req_valid held until the response
        exp_resp.push_back('{rdata: 16'h0000, chk_rdata: 1'b0, err: 1'b1});
        issue(2'd3, 22'h000055, 16'h0000, 1'b1, lat);
        check("rsvd_latency", 64'(lat), 64'd2);

        repeat (20) @(negedge clk);
        check("bus_queue_drained",  64'(exp_bus.size()),  64'd0);
        check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
